// File: rtl/chunked_seq_adder_if.sv
// Operand/result handshake bundle for chunked_seq_adder.
// The master side feeds operands and sinks results; the slave is the adder.
interface chunked_seq_adder_if #(
  parameter int unsigned WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             ovf;

  modport master (
    output in_valid, a, b, c_in, sub, out_ready,
    input  in_ready, out_valid, sum, c_out, ovf
  );

  modport slave (
    input  in_valid, a, b, c_in, sub, out_ready,
    output in_ready, out_valid, sum, c_out, ovf
  );
endinterface

// File: rtl/chunked_seq_adder.sv
// Multi-cycle WIDTH-bit add/subtract: one CHUNK-bit ripple slice per clock,
// carry chained through a register, valid/ready on both sides.
module chunked_seq_adder #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned CHUNK = 8
) (
  input logic                clk,
  input logic                rst_n,
  chunked_seq_adder_if.slave bus
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int unsigned IW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned SW     = CHUNK + 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             c_out_q;
  logic             ovf_q;
  logic             out_valid_q;

  logic [IW-1:0]    base_c;
  logic [SW-1:0]    slice_c;
  logic             last_c;

  // Current slice: bits [cnt*CHUNK +: CHUNK] of a + b_eff + carry.
  always_comb begin
    base_c  = IW'(CHUNK) * IW'(cnt_q);
    slice_c = {1'b0, a_q[base_c +: CHUNK]} + {1'b0, b_q[base_c +: CHUNK]} + SW'(carry_q);
    last_c  = (cnt_q == CW'(NCHUNK - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      c_out_q     <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_q     <= bus.a;
            b_q     <= bus.sub ? ~bus.b : bus.b;
            carry_q <= bus.sub | bus.c_in;
            cnt_q   <= '0;
            sum_q   <= '0;
            state_q <= CALC;
          end
        end
        CALC: begin
          sum_q[base_c +: CHUNK] <= slice_c[CHUNK-1:0];
          carry_q                <= slice_c[CHUNK];
          if (last_c) begin
            // Top slice holds bit WIDTH-1, so its MSB is the new sign bit.
            c_out_q     <= slice_c[CHUNK];
            ovf_q       <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                           (slice_c[CHUNK-1] != a_q[WIDTH-1]);
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.c_out     = c_out_q;
  assign bus.ovf       = ovf_q;

endmodule
